sincronizador_rx: RTL and testbench
===================================

SINCRONIZADOR_RX -- requirements
Module: sincronizador_rx

Interface
REQ-001 Parameter COM_SYMBOL, default 8'hBC, comma/alignment symbol.
REQ-002 Parameter COM_COUNT, default 4, consecutive aligned COMs needed to reach sync.
REQ-003 Parameter LOSS_LIMIT, default 16, bytes without COM before sync loss (used only under REQ-024).
REQ-004 clk  input  1  bit-rate clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 data_in  input  1  serial receive bit, MSB of each byte first.
REQ-007 active  output  1  high while in SYNC; drives the parallel/serial RX datapath enable.
REQ-008 data_out  output  8  last aligned byte received in SYNC.
REQ-009 valid_out  output  1  one-cycle pulse when data_out updates.

Function
REQ-010 Shift register sr[7:0] shall load {sr[6:0], data_in} every clock; cand = {sr[6:0], data_in} is the candidate byte at that edge.
REQ-011 FSM states: SEARCH, ALIGN, SYNC. Internals: bit_cnt[2:0], com_cnt, byte_cnt.
REQ-012 SEARCH: at any edge with cand == COM_SYMBOL -> ALIGN; bit_cnt <= 0; com_cnt <= 1. Otherwise remain; bit_cnt held at 0.
REQ-013 ALIGN/SYNC: bit_cnt shall increment every clock, wrapping 7->0; a byte boundary is an edge with bit_cnt == 7, so boundaries fall exactly 8 clocks apart after the detecting edge.
REQ-014 ALIGN boundary, cand == COM_SYMBOL: com_cnt+1; if it equals COM_COUNT -> SYNC, active <= 1 on the same edge.
REQ-015 ALIGN boundary, cand != COM_SYMBOL: -> SEARCH, com_cnt <= 0; the non-COM byte shall not be searched again for an embedded COM on that edge.
REQ-016 ALIGN non-boundary edges: no state change; COM patterns at other bit offsets ignored.
REQ-017 SYNC boundary: data_out <= cand; valid_out <= 1 for exactly one clock; COM bytes are also output.
REQ-018 The COM byte completing sync (REQ-014) shall not be output; first valid_out is the next boundary, 8 clocks later.
REQ-019 valid_out shall be 0 on every non-boundary edge and in SEARCH/ALIGN; data_out holds its value between pulses.
REQ-020 active shall be a registered output: 1 only in SYNC, 0 in SEARCH/ALIGN.
REQ-021 com_cnt shall saturate at COM_COUNT; widths shall be sized by $clog2 of the parameters.

Reset
REQ-022 reset high shall immediately (asynchronously) force: state SEARCH, sr 8'h00, bit_cnt 0, com_cnt 0, byte_cnt 0, active 0, data_out 8'h00, valid_out 0.
REQ-023 Reset asserted mid-byte or in SYNC shall discard partial data; after release, alignment restarts from SEARCH with no output until a new sync sequence completes.

Configuration
REQ-024 Macro SYNC_LOSS_EN defined: in SYNC, byte_cnt clears on a COM boundary and increments on any other boundary; on reaching LOSS_LIMIT -> SEARCH, active <= 0 on that edge; that final byte is still output with valid_out.
REQ-025 SYNC_LOSS_EN undefined: SYNC is left only by reset; byte_cnt logic absent.

Verification
REQ-026 Reset, then 4x 8'hBC serial MSB-first, then 8'h5A -> active rises on the edge sampling the last bit of 4th BC; valid_out pulses 8 clocks later with data_out 8'h5A.
REQ-027 Junk bits 3'b101 then 4x BC -> alignment at bit offset 3; same response as REQ-026.
REQ-028 BC, BC, 8'h00, BC, BC, BC, BC -> return to SEARCH after 3rd byte; active rises only after 7th byte, no valid_out before.
REQ-029 In SYNC, assert reset for 1 clock mid-byte -> active 0, data_out 8'h00 immediately; following bytes produce no valid_out until 4 new BCs.
REQ-030 SYNC_LOSS_EN: in SYNC send 16 bytes of 8'h11 -> 16 valid_out pulses, active falls on 16th boundary; with a BC as 10th byte, active stays 1.

Source files
------------

// File: rtl/sincronizador_rx.sv
`default_nettype none
// ============================================================================
// Module      : sincronizador_rx
// Description : Serial comma-based byte aligner. Optional macro SYNC_LOSS_EN
//               drops sync after LOSS_LIMIT bytes without a comma.
// Revision    : 1.0 - initial release
// ============================================================================
module sincronizador_rx #(
   parameter logic [7:0] COM_SYMBOL = 8'hBC,
   parameter int         COM_COUNT  = 4,
   parameter int         LOSS_LIMIT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       data_in,
   output logic       active,
   output logic [7:0] data_out,
   output logic       valid_out
);

   localparam int CW = $clog2(COM_COUNT + 1);

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      ALIGN  = 2'd1,
      SYNC   = 2'd2
   } state_t;

   state_t          state_q;
   logic [7:0]      sr_q;
   logic [7:0]      sr_d;
   logic [2:0]      bit_cnt_q;
   logic [CW-1:0]   com_cnt_q;
   logic [CW-1:0]   com_cnt_d;
   logic            active_q;
   logic [7:0]      data_out_q;
   logic            valid_out_q;
   logic            boundary_d;
   logic            is_com_d;

   assign sr_d       = {sr_q[6:0], data_in};
   assign is_com_d   = (sr_d == COM_SYMBOL);
   assign boundary_d = (bit_cnt_q == 3'd7);
   assign com_cnt_d  = (com_cnt_q == CW'(COM_COUNT)) ? com_cnt_q : com_cnt_q + CW'(1);

`ifdef SYNC_LOSS_EN
   localparam int BW = $clog2(LOSS_LIMIT + 1);
   logic [BW-1:0] byte_cnt_q;
   logic [BW-1:0] byte_cnt_d;
   assign byte_cnt_d = byte_cnt_q + BW'(1);
`else
   logic unused_loss_limit;
   assign unused_loss_limit = (LOSS_LIMIT == 0);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= SEARCH;
         sr_q        <= 8'h00;
         bit_cnt_q   <= 3'd0;
         com_cnt_q   <= '0;
         active_q    <= 1'b0;
         data_out_q  <= 8'h00;
         valid_out_q <= 1'b0;
`ifdef SYNC_LOSS_EN
         byte_cnt_q  <= '0;
`endif
      end else begin
         sr_q        <= sr_d;
         valid_out_q <= 1'b0;
         case (state_q)
            SEARCH: begin
               bit_cnt_q <= 3'd0;
               if (is_com_d) begin
                  state_q   <= ALIGN;
                  com_cnt_q <= CW'(1);
               end
            end
            ALIGN: begin
               bit_cnt_q <= bit_cnt_q + 3'd1;
               // Only byte boundaries are examined; off-phase commas are ignored.
               if (boundary_d) begin
                  if (is_com_d) begin
                     com_cnt_q <= com_cnt_d;
                     if (com_cnt_d == CW'(COM_COUNT)) begin
                        state_q  <= SYNC;
                        active_q <= 1'b1;
                     end
                  end else begin
                     state_q   <= SEARCH;
                     com_cnt_q <= '0;
                  end
               end
            end
            SYNC: begin
               bit_cnt_q <= bit_cnt_q + 3'd1;
               if (boundary_d) begin
                  data_out_q  <= sr_d;
                  valid_out_q <= 1'b1;
`ifdef SYNC_LOSS_EN
                  if (is_com_d) begin
                     byte_cnt_q <= '0;
                  end else if (byte_cnt_d == BW'(LOSS_LIMIT)) begin
                     // The final byte is still delivered on this edge.
                     state_q    <= SEARCH;
                     active_q   <= 1'b0;
                     com_cnt_q  <= '0;
                     byte_cnt_q <= '0;
                  end else begin
                     byte_cnt_q <= byte_cnt_d;
                  end
`endif
               end
            end
            default: begin
               state_q  <= SEARCH;
               active_q <= 1'b0;
            end
         endcase
      end
   end

   assign active    = active_q;
   assign data_out  = data_out_q;
   assign valid_out = valid_out_q;

endmodule
`default_nettype wire

// File: tb/tb_sincronizador_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_sincronizador_rx
// Description : Scoreboard bench for sincronizador_rx (set SYNC_LOSS_EN to
//               exercise the sync-loss path).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sincronizador_rx;

   logic       clk = 1'b0;
   logic       reset;
   logic       data_in;
   logic       active;
   logic [7:0] data_out;
   logic       valid_out;

   int tests_run = 0;
   int tests_failed = 0;
   logic [7:0] sb[$];

   sincronizador_rx dut (
      .clk       (clk),
      .reset     (reset),
      .data_in   (data_in),
      .active    (active),
      .data_out  (data_out),
      .valid_out (valid_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Output monitor: every pulse must match the oldest expected byte.
   always @(posedge clk) begin
      #1;
      if (valid_out === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_valid", 32'(valid_out), 32'd0);
         end else begin
            check("data_out", 32'(data_out), 32'(sb.pop_front()));
         end
      end
   end

   task automatic send_bit(input logic b);
      @(negedge clk);
      data_in = b;
      @(posedge clk);
      #2;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit expect_out);
      if (expect_out) sb.push_back(b);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      if (expect_out) check("pulse_on_boundary", 32'(sb.size()), 32'd0);
   endtask

   task automatic send_com(input int n);
      for (int i = 0; i < n; i++) send_byte(8'hBC, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset   = 1'b1;
      data_in = 1'b0;
      #1;
      check("reset_active", 32'(active), 32'd0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] com;
      com     = 8'hBC;
      reset   = 1'b1;
      data_in = 1'b0;
      @(posedge clk);
      #2;
      check("rst_active",   32'(active),    32'd0);
      check("rst_data_out", 32'(data_out),  32'd0);
      check("rst_valid",    32'(valid_out), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Four commas then a data byte; COM bytes in SYNC are also delivered.
      send_com(3);
      for (int i = 7; i >= 1; i--) send_bit(com[i]);
      check("t26_active_early", 32'(active), 32'd0);
      send_bit(com[0]);
      check("t26_active_rise", 32'(active), 32'd1);
      send_byte(8'h5A, 1'b1);
      send_byte(8'hBC, 1'b1);
      send_byte(8'h3C, 1'b1);
      check("t26_active_hold", 32'(active), 32'd1);

      // Alignment at a 3-bit offset.
      do_reset();
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      send_com(3);
      check("t27_active_early", 32'(active), 32'd0);
      send_com(1);
      check("t27_active_rise", 32'(active), 32'd1);
      send_byte(8'hA5, 1'b1);

      // A non-COM byte during alignment restarts the search.
      do_reset();
      send_com(2);
      send_byte(8'h00, 1'b0);
      send_com(3);
      check("t28_active_6th", 32'(active), 32'd0);
      send_com(1);
      check("t28_active_7th", 32'(active), 32'd1);
      send_byte(8'h5A, 1'b1);

      // Asynchronous reset mid-byte while in SYNC.
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
      #1;
      reset = 1'b1;
      #1;
      check("t29_async_active",   32'(active),   32'd0);
      check("t29_async_data_out", 32'(data_out), 32'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      send_byte(8'h5A, 1'b0);
      send_byte(8'h77, 1'b0);
      send_byte(8'h5A, 1'b0);
      check("t29_active_after", 32'(active), 32'd0);
      send_com(4);
      check("t29_resync", 32'(active), 32'd1);
      send_byte(8'h66, 1'b1);

`ifdef SYNC_LOSS_EN
      do_reset();
      send_com(4);
      for (int i = 0; i < 15; i++) send_byte(8'h11, 1'b1);
      check("t30_active_15", 32'(active), 32'd1);
      send_byte(8'h11, 1'b1);
      check("t30_active_16", 32'(active), 32'd0);
      send_com(4);
      for (int i = 0; i < 9; i++) send_byte(8'h11, 1'b1);
      send_byte(8'hBC, 1'b1);
      for (int i = 0; i < 6; i++) send_byte(8'h11, 1'b1);
      check("t30_active_com_reset", 32'(active), 32'd1);
`endif

      repeat (3) @(posedge clk);
      #2;
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire
